// File: rtl/instr_issuer.sv
// Host-side instruction issuer: buffers host words in a FIFO and hands them to the CPU one at a time.
// Optional CPU-stall watchdog is built when INSTR_ISSUER_WATCHDOG_EN is defined.
module instr_issuer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        run,
    input  logic        cpu_w,
    input  logic [15:0] cpu_out,
    output logic [15:0] cpu_in,
    output logic        cpu_load,
    output logic        cpu_s,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic [15:0] last_out,
    output logic [7:0]  done_count,
    output logic        timeout
);

    localparam int DATA_W = 16;
    localparam int AW     = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_issuer: DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("instr_issuer: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              push_ok, pop, retire;

    assign push_ok = push && !full;
    assign pop     = (state == S_LOAD);
    assign retire  = (state == S_WAIT_HI) && cpu_w;
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef INSTR_ISSUER_WATCHDOG_EN
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = 1;

    logic [WCW-1:0] wait_cnt;
    logic           wd_fire;

    // Fires on the TIMEOUT-th WAIT_LO cycle in which the CPU never dropped cpu_w.
    assign wd_fire = (state == S_WAIT_LO) && cpu_w && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == S_START) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT_LO) begin
                wait_cnt <= wait_cnt + WAIT_ONE;
            end
            if (wd_fire) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run && !empty && cpu_w) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_START;
            S_START: state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!cpu_w) begin
                    state_nxt = S_WAIT_HI;
                end
`ifdef INSTR_ISSUER_WATCHDOG_EN
                else if (wd_fire) begin
                    state_nxt = S_IDLE;
                end
`endif
            end
            S_WAIT_HI: begin
                if (cpu_w) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_load = 1'b0;
        cpu_s    = 1'b0;
        cpu_in   = '0;
        busy     = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                cpu_load = 1'b1;
                cpu_in   = mem[rd_ptr];
            end
            S_START: cpu_s = 1'b1;
            default: ;
        endcase
    end

    // Result capture happens only on a genuine completion, never on a watchdog exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_out   <= '0;
            done_count <= '0;
        end else if (retire) begin
            last_out   <= cpu_out;
            done_count <= done_count + 8'd1;
        end
    end

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Host-side instruction issuer that drives the CPU core's instruction handshake from the opposite end. It buffers 16-bit instructions pushed by a host (switch logic or bench) in a small FIFO. For each instruction it presents the word with a one-cycle load, pulses start, then waits for the CPU's wait flag to fall and rise again. On completion it captures the CPU result and counts retired instructions.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TIMEOUT, 4, cycles allowed in WAIT_LO for cpu_w to fall (watchdog build only).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low. Low clears all state immediately.
- push  in  1  host write strobe.
- push_data  in  16  instruction to enqueue.
- run  in  1  issue enable; when low, no new instruction leaves IDLE.
- cpu_w  in  1  CPU wait flag; 1 = CPU idle/ready.
- cpu_out  in  16  CPU datapath output.
- cpu_in  out  16  instruction to the CPU instruction register.
- cpu_load  out  1  CPU instruction-register load enable.
- cpu_s  out  1  CPU start.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  state != IDLE.
- last_out  out  16  cpu_out captured at the last completion.
- done_count  out  8  retired-instruction counter.
- timeout  out  1  sticky watchdog flag.

## Operation
- Reset values (asserted asynchronously while reset=0):
  - state IDLE; FIFO pointers 0; empty=1, full=0.
  - cpu_in=0, cpu_load=0, cpu_s=0, busy=0.
  - last_out=0, done_count=0, timeout=0.
- FIFO:
  - A push is accepted iff push=1 and full=0 at the edge. A push while full is silently dropped; contents are unchanged.
  - The pop occurs at the edge that ends LOAD.
  - Push and pop at the same edge (not full): both occur; occupancy is unchanged.
  - Pointers wrap modulo DEPTH. full/empty are derived from an occupancy count of log2(DEPTH)+1 bits.
- State machine (Moore; outputs decode from the state register):
  - IDLE: go to LOAD when run=1, empty=0 and cpu_w=1; otherwise stay.
  - LOAD: cpu_load=1 and cpu_in = FIFO head. Go to START unconditionally; pop the FIFO.
  - START: cpu_s=1. Go to WAIT_LO.
  - WAIT_LO:
    - cpu_w=0 → WAIT_HI.
    - Otherwise stay, incrementing a wait counter that is cleared on entry.
  - WAIT_HI:
    - cpu_w=1 → IDLE. On that edge, last_out ← cpu_out and done_count increments (255 wraps to 0).
    - Otherwise stay.
- cpu_in is 0 in every state except LOAD.
- Dropping run mid-instruction does not abort it; run is sampled only in IDLE.
- An instruction word of 0x0000 is issued like any other word.

## Timing
- Push at edge k into an empty FIFO (run=1, cpu_w=1):
  - empty=0 after edge k.
  - IDLE→LOAD at edge k+1; cpu_load high during cycle k+1..k+2.
  - cpu_s high during the next cycle.
- Issue overhead: 3 cycles (IDLE, LOAD, START) plus the CPU's busy time plus 1 cycle to retire.
- Back-to-back instructions: after retiring to IDLE, the next LOAD follows one cycle later if the FIFO is non-empty.
- last_out and done_count update on the same edge that leaves WAIT_HI.
- Reset asserted mid-instruction: the machine returns to IDLE at once and FIFO contents are discarded. No partial capture occurs.

## Configuration
- INSTR_ISSUER_WATCHDOG_EN defined:
  - If the WAIT_LO counter reaches TIMEOUT with cpu_w still 1, go to IDLE.
  - timeout is set sticky until reset.
  - done_count and last_out are unchanged.
- Not defined:
  - WAIT_LO waits indefinitely.
  - timeout is tied to 0 and the wait counter is not built.

## Test plan
- Reset: drive reset=0 mid-WAIT_HI with 3 entries queued → immediately empty=1, busy=0, done_count=0, last_out=0; all outputs hold while reset=0.
- Single issue: push 0xD105, model the CPU with cpu_w low for 2 cycles and cpu_out=0x0005 → cpu_load pulses for exactly 1 cycle with cpu_in=0xD105, then cpu_s for 1 cycle. After the CPU completes: last_out=0x0005, done_count=1.
- FIFO full/wrap (DEPTH=8):
  - Push 9 words → full=1 after the 8th; the 9th is dropped.
  - Issue all 8 with run=1 → words emerge in push order; done_count=8; empty=1.
  - Push 3 more → pointers wrap and order is preserved.
- Simultaneous push/pop: push exactly on the LOAD→START edge with 4 queued → occupancy stays 4; no word is lost or duplicated.
- run gating: run=0 with 2 queued → no cpu_load for 20 cycles. Lower run during WAIT_HI → the current instruction retires (done_count+1) and the next is not issued.
- Watchdog (macro defined, TIMEOUT=4): hold cpu_w=1 → IDLE within 4 cycles after cpu_s, timeout=1, done_count unchanged.
